// File: rtl/synapse_accumulator_if.sv
// Spike/config handshake, weight-BRAM port and neuron outputs of the synapse accumulator.
// master = host plus BRAM side, slave = the accumulator.
interface synapse_accumulator_if #(
  parameter int BRAM_WIDTH = 32,
  parameter int BRAM_DEPTH = 64,
  parameter int WEIGHT_W   = 8,
  parameter int POT_W      = 16
);
  localparam int N  = BRAM_WIDTH / WEIGHT_W;
  localparam int AW = $clog2(BRAM_DEPTH);

  logic                  spike_valid;
  logic [AW-1:0]         spike_src;
  logic                  spike_ready;
  logic                  tick;
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [BRAM_WIDTH-1:0] cfg_din;
  logic                  cfg_ready;
  logic [AW-1:0]         mem_addr;
  logic [BRAM_WIDTH-1:0] mem_din;
  logic                  mem_we;
  logic [BRAM_WIDTH-1:0] mem_dout;
  logic                  fire_valid;
  logic [N-1:0]          fire_vec;
  logic [N*POT_W-1:0]    pot_out;
  logic                  busy;

  modport master (
    output spike_valid, spike_src, tick, cfg_we, cfg_addr, cfg_din, mem_dout,
    input  spike_ready, cfg_ready, mem_addr, mem_din, mem_we,
           fire_valid, fire_vec, pot_out, busy
  );

  modport slave (
    input  spike_valid, spike_src, tick, cfg_we, cfg_addr, cfg_din, mem_dout,
    output spike_ready, cfg_ready, mem_addr, mem_din, mem_we,
           fire_valid, fire_vec, pot_out, busy
  );
endinterface

// File: rtl/synapse_accumulator.sv
// Spike-driven synapse accumulator: reads a packed weight word per spike, adds each weight
// into its local neuron's saturating membrane potential, and fires/clears neurons on tick.
module synapse_accumulator #(
  parameter int BRAM_WIDTH = 32,
  parameter int BRAM_DEPTH = 64,
  parameter int WEIGHT_W   = 8,
  parameter int POT_W      = 16,
  parameter int THRESHOLD  = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  synapse_accumulator_if.slave  bus
);
  localparam int N = BRAM_WIDTH / WEIGHT_W;
  localparam logic signed [POT_W-1:0] THR = POT_W'(THRESHOLD);

  typedef enum logic [1:0] {IDLE, ACC, TICK} state_t;

  state_t                  state, state_nxt;
  logic                    tick_pend, tick_pend_nxt;
  logic signed [POT_W-1:0] pot [N];
  logic [N-1:0]            fire_vec_q;
  logic                    fire_valid_q;

  // Sum at POT_W+1 bits; a sign mismatch between the top two bits means overflow.
  function automatic logic signed [POT_W-1:0] sat_add(
    input logic signed [POT_W-1:0]    p,
    input logic signed [WEIGHT_W-1:0] w
  );
    logic [POT_W:0] sum;
    sum = {p[POT_W-1], p} + {{(POT_W+1-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    if (sum[POT_W] != sum[POT_W-1])
      sat_add = sum[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
    else
      sat_add = sum[POT_W-1:0];
  endfunction

  // NOTE: every output and next-state variable gets a default before the case so no
  // path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_nxt        = state;
    tick_pend_nxt    = tick_pend;
    bus.spike_ready  = 1'b0;
    bus.cfg_ready    = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_din      = '0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          bus.cfg_ready   = 1'b1;
          bus.spike_ready = !bus.cfg_we && !tick_pend && !bus.tick;
          tick_pend_nxt   = tick_pend || bus.tick;
          if (bus.cfg_we) begin
            bus.mem_we   = 1'b1;
            bus.mem_addr = bus.cfg_addr;
            bus.mem_din  = bus.cfg_din;
          end else if (bus.tick || tick_pend) begin
            state_nxt = TICK;
          end else if (bus.spike_valid) begin
            bus.mem_addr = bus.spike_src;
            state_nxt    = ACC;
          end
        end
        ACC: begin
          tick_pend_nxt = tick_pend || bus.tick;
          state_nxt     = IDLE;
        end
        TICK: begin
          // The pending tick is serviced here; only a tick arriving now stays pending.
          tick_pend_nxt = bus.tick;
          state_nxt     = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_pend    <= 1'b0;
      fire_valid_q <= 1'b0;
      fire_vec_q   <= '0;
      // NOTE: the potentials are a few flops, not a RAM, so they are reset explicitly.
      for (int i = 0; i < N; i++) pot[i] <= '0;
    end else begin
      state        <= state_nxt;
      tick_pend    <= tick_pend_nxt;
      fire_valid_q <= (state == TICK);
      if (state == ACC) begin
        for (int i = 0; i < N; i++)
          pot[i] <= sat_add(pot[i], bus.mem_dout[i*WEIGHT_W +: WEIGHT_W]);
      end
      if (state == TICK) begin
        for (int i = 0; i < N; i++) begin
          fire_vec_q[i] <= (pot[i] >= THR);
          if (pot[i] >= THR) pot[i] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pot_out
    assign bus.pot_out[g*POT_W +: POT_W] = pot[g];
  end

  assign bus.fire_valid = fire_valid_q;
  assign bus.fire_vec   = fire_vec_q;
  assign bus.busy       = (state != IDLE) || tick_pend;
endmodule

// File: tb/tb_synapse_accumulator.sv
// Randomized scoreboard bench for synapse_accumulator: a driver updates an arithmetic
// neuron model and queues expectations; a monitor compares whenever the DUT reports.
module tb_synapse_accumulator;
  localparam int BW = 32;
  localparam int BD = 64;
  localparam int WW = 8;
  localparam int PW = 16;
  localparam int NN = BW / WW;
  localparam int TH = 100;

  typedef struct {
    logic [NN-1:0]    vec;
    logic [NN*PW-1:0] pots;
  } fire_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  synapse_accumulator_if #(.BRAM_WIDTH(BW), .BRAM_DEPTH(BD), .WEIGHT_W(WW), .POT_W(PW)) bus ();

  synapse_accumulator #(
    .BRAM_WIDTH(BW), .BRAM_DEPTH(BD), .WEIGHT_W(WW), .POT_W(PW), .THRESHOLD(TH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port BRAM, read-first, one cycle read latency.
  logic [BW-1:0] bram [BD];
  always @(posedge clk) begin
    if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= bram[bus.mem_addr];
  end

  // Reference model: host view of the weight table and plain-integer potentials.
  logic [BW-1:0]    mem_m [BD];
  int               pot_m [NN];
  logic [NN*PW-1:0] pot_q [$];
  fire_t            fire_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NN*PW-1:0] pack_pots();
    logic [NN*PW-1:0] v;
    v = '0;
    for (int i = 0; i < NN; i++) v[i*PW +: PW] = PW'(pot_m[i]);
    return v;
  endfunction

  function automatic void model_spike(input int src);
    logic [WW-1:0] wb;
    int s;
    for (int i = 0; i < NN; i++) begin
      wb = mem_m[src][i*WW +: WW];
      s  = pot_m[i] + int'($signed(wb));
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      pot_m[i] = s;
    end
    pot_q.push_back(pack_pots());
  endfunction

  function automatic void model_tick();
    fire_t f;
    f.vec = '0;
    for (int i = 0; i < NN; i++) begin
      if (pot_m[i] >= TH) begin
        f.vec[i] = 1'b1;
        pot_m[i] = 0;
      end
    end
    f.pots = pack_pots();
    fire_q.push_back(f);
  endfunction

  // Monitor: samples on the falling edge, away from the driver's posedge+1 updates.
  bit acc_d1 = 0, acc_d2 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_d1 = 0;
      acc_d2 = 0;
    end else begin
      if (acc_d2) begin
        if (pot_q.size() == 0) check("pot_unexpected", 64'd1, 64'd0);
        else check("pot_after_acc", 64'(bus.pot_out), 64'(pot_q.pop_front()));
      end
      acc_d2 = acc_d1;
      acc_d1 = bus.spike_valid && bus.spike_ready;
      if (bus.spike_valid && bus.spike_ready)
        check("spike_mem_port", 64'({bus.mem_we, bus.mem_addr}), 64'({1'b0, bus.spike_src}));
      if (bus.fire_valid) begin
        if (fire_q.size() == 0) check("fire_unexpected", 64'd1, 64'd0);
        else begin
          fire_t f;
          f = fire_q.pop_front();
          check("fire_vec", 64'(bus.fire_vec), 64'(f.vec));
          check("fire_pots", 64'(bus.pot_out), 64'(f.pots));
        end
      end
      if (!bus.cfg_we)
        check("quiet_mem_bus", 64'({bus.mem_we, bus.mem_din}), 64'd0);
      if (bus.cfg_we && bus.cfg_ready)
        check("cfg_mem_bus", 64'({bus.mem_we, bus.mem_addr, bus.mem_din}),
              64'({1'b1, bus.cfg_addr, bus.cfg_din}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [5:0] addr, input logic [BW-1:0] din);
    bit done = 0;
    bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_din = din;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.cfg_ready) begin
        mem_m[addr] = din;
        done = 1;
      end
      step();
    end
    bus.cfg_we = 1'b0;
    if (!done) check("cfg_timeout", 64'd0, 64'd1);
  endtask

  // Returns at posedge+1 of the ACC cycle when the spike was accepted.
  task automatic do_spike(input logic [5:0] src);
    bit done = 0;
    bus.spike_valid = 1'b1; bus.spike_src = src;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.spike_ready) begin
        model_spike(int'(src));
        done = 1;
      end
      step();
    end
    bus.spike_valid = 1'b0;
    if (!done) check("spike_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!bus.busy) done = 1;
    end
    if (!done) check("idle_timeout", 64'd0, 64'd1);
    step();
  endtask

  task automatic do_tick();
    wait_idle();
    bus.tick = 1'b1;
    model_tick();
    step();
    bus.tick = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_fire, done;
    int r;
    rst_n = 1'b0;
    bus.spike_valid = 1'b0; bus.spike_src = '0; bus.tick = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_din = '0;
    for (int i = 0; i < BD; i++) begin bram[i] = '0; mem_m[i] = '0; end
    for (int i = 0; i < NN; i++) pot_m[i] = 0;

    // Reset state, including a host write attempt that must not reach the BRAM.
    step(); step();
    bus.cfg_we = 1'b1; bus.cfg_addr = 6'd9; bus.cfg_din = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rst_mem_bus", 64'({bus.mem_we, bus.mem_addr, bus.mem_din}), 64'd0);
    check("rst_pot_out", 64'(bus.pot_out), 64'd0);
    check("rst_fire", 64'({bus.fire_valid, bus.fire_vec}), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    step();
    bus.cfg_we = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'({bus.spike_ready, bus.cfg_ready}), 64'd3);
    step();

    // Directed accumulation: weights 127,-10,10,5 into neurons 0..3.
    do_cfg(6'd3, 32'h050A_F67F);
    do_spike(6'd3);
    @(negedge clk);
    check("acc_spike_ready", 64'(bus.spike_ready), 64'd0);
    check("acc_busy", 64'(bus.busy), 64'd1);
    step();
    do_spike(6'd3);
    do_tick();

    // Tick twice around an ACC cycle with a spike held high: one fire, spike waits.
    wait_idle();
    do_spike(6'd3);
    model_tick();
    bus.tick = 1'b1; bus.spike_valid = 1'b1; bus.spike_src = 6'd3;
    @(negedge clk);
    check("tick_in_acc_busy", 64'({bus.busy, bus.spike_ready}), 64'd2);
    step();
    @(negedge clk);
    check("tick_pend_busy", 64'({bus.busy, bus.spike_ready}), 64'd2);
    step();
    bus.tick = 1'b0;
    seen_fire = 0; done = 0;
    for (int n = 0; n < 12 && !done; n++) begin
      @(negedge clk);
      if (bus.fire_valid) seen_fire = 1;
      if (bus.spike_ready) begin
        check("held_spike_after_fire", 64'(seen_fire), 64'd1);
        model_spike(3);
        done = 1;
      end
      step();
    end
    bus.spike_valid = 1'b0;
    if (!done) check("held_spike_timeout", 64'd0, 64'd1);

    // Host write and spike offered together: write wins, spike reads the new word next cycle.
    wait_idle();
    bus.cfg_we = 1'b1; bus.cfg_addr = 6'd5; bus.cfg_din = 32'hF1_23_45_E7;
    bus.spike_valid = 1'b1; bus.spike_src = 6'd5;
    @(negedge clk);
    check("collide_spike_ready", 64'(bus.spike_ready), 64'd0);
    check("collide_mem_we", 64'(bus.mem_we), 64'd1);
    mem_m[5] = 32'hF1_23_45_E7;
    step();
    bus.cfg_we = 1'b0;
    @(negedge clk);
    check("collide_spike_next", 64'(bus.spike_ready), 64'd1);
    model_spike(5);
    step();
    bus.spike_valid = 1'b0;

    // Randomized mix of host writes, spikes and ticks.
    for (int k = 0; k < 150; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20) do_cfg(6'($urandom_range(0, BD-1)), $urandom);
      else if (r < 85) do_spike(6'($urandom_range(0, 15)));
      else do_tick();
    end

    // Positive saturation from any starting potential, then fire everything.
    do_cfg(6'd0, 32'h7F7F_7F7F);
    for (int k = 0; k < 600; k++) do_spike(6'd0);
    do_tick();

    // Reset during ACC with a tick arriving: spike and tick are dropped.
    do_cfg(6'd7, 32'h0102_0304);
    do_spike(6'd7);
    do_spike(6'd7);
    bus.tick = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < NN; i++) pot_m[i] = 0;
    pot_q.delete();
    @(negedge clk);
    check("midrst_pot_out", 64'(bus.pot_out), 64'd0);
    check("midrst_fire", 64'({bus.fire_valid, bus.fire_vec}), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    step();
    bus.tick = 1'b0;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("post_rst_no_fire", 64'(bus.fire_valid), 64'd0);
    end
    step();

    // Negative saturation floors at -32768; nothing fires.
    do_cfg(6'd1, 32'h8080_8080);
    for (int k = 0; k < 600; k++) do_spike(6'd1);
    do_tick();

    wait_idle();
    repeat (4) @(negedge clk);
    check("pot_q_drained", 64'(pot_q.size()), 64'd0);
    check("fire_q_drained", 64'(fire_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/synapse_accumulator.md
Name: synapse_accumulator

Overview:
- Spike-driven consumer of the PE's single-port weight BRAM; sole driver of the BRAM's address, data and write-enable inputs.
- On each incoming spike, reads the weight word for the source neuron and adds each packed weight into the membrane potential of the matching local neuron, with saturation.
- On each tick, fires every neuron at or above threshold and clears its potential.
- Also gives the host a weight-load (config write) path into the BRAM.

Parameters:
- BRAM_WIDTH, 32, weight word width (multiple of WEIGHT_W)
- BRAM_DEPTH, 64, number of source neurons (BRAM words)
- WEIGHT_W, 8, signed weight width
- POT_W, 16, signed membrane potential width
- THRESHOLD, 100, signed firing threshold (POT_W bits)
- Derived: N = BRAM_WIDTH/WEIGHT_W local neurons (default 4); AW = $clog2(BRAM_DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- spike_valid  in  1  spike offered
- spike_src  in  AW  source neuron index
- spike_ready  out  1  spike accepted when valid&ready at clk edge
- tick  in  1  one-cycle timestep pulse
- cfg_we  in  1  host weight write request
- cfg_addr  in  AW  host write address
- cfg_din  in  BRAM_WIDTH  host write data
- cfg_ready  out  1  cfg write performed when cfg_we&cfg_ready at edge
- mem_addr  out  AW  to BRAM addr
- mem_din  out  BRAM_WIDTH  to BRAM din
- mem_we  out  1  to BRAM we
- mem_dout  in  BRAM_WIDTH  from BRAM dout (valid the cycle after address is sampled)
- fire_valid  out  1  one-cycle pulse, fire_vec updated
- fire_vec  out  N  bit i = neuron i fired
- pot_out  out  N*POT_W  potentials, neuron i at bits [i*POT_W +: POT_W]
- busy  out  1  state != IDLE or tick pending

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, all potentials 0, tick_pend=0.
  - fire_valid=0, fire_vec=0, mem_we=0, mem_addr=0, mem_din=0.
  - spike_ready and cfg_ready follow IDLE rules once rst_n is high.
- FSM states:
  - IDLE:
    - cfg_ready=1 always.
    - spike_ready = !cfg_we & !tick_pend & !tick.
    - Priority: cfg_we > tick/tick_pend > spike.
  - CFG write:
    - mem_we=cfg_we, mem_addr=cfg_addr, mem_din=cfg_din, all combinational in IDLE.
    - Completes in one cycle; state stays IDLE.
  - Spike:
    - On accept, mem_addr=spike_src combinational, mem_we=0.
    - BRAM samples the address at edge T; state goes to ACC.
  - ACC (cycle T+1):
    - mem_dout holds the weight word, weight i at [i*WEIGHT_W +: WEIGHT_W].
    - At edge T+1, pot[i] <= sat(pot[i] + sext(w_i)); state goes to IDLE.
    - Throughput is one spike per 2 cycles.
  - TICK:
    - Entered from IDLE when tick or tick_pend is set and cfg_we=0.
    - At its edge: fire_vec[i] <= (pot[i] >= THRESHOLD, signed); pot[i] <= 0 where fired, else unchanged.
    - fire_valid=1 in the following cycle only; tick_pend cleared; return to IDLE.
    - fire_vec holds until the next TICK.
- tick while not IDLE, or while cfg_we blocks it: latched into tick_pend. Multiple ticks before service collapse into one.
- Saturation: sum computed at POT_W+1 bits, clamped to [-2^(POT_W-1), 2^(POT_W-1)-1].
- Outside cfg writes, mem_we=0 and mem_din=0.
- spike_src is not range-checked; the BRAM decodes any index.
- Reset mid-operation: any in-flight spike and pending tick are dropped; no fire_valid is produced.
- pot_out is a registered view; it updates on the edge ending ACC or TICK.

Test Plan:
- Reset, then cfg write addr 3 = 0x05_0A_F6_7F; spike src 3 -> spike_ready low in ACC cycle; pot = {5,10,-10,127} (neuron3..0 = 5,10,-10,127) two cycles after accept.
- Repeat that spike 1 time more, then tick -> fire_vec=4'b0001 (254>=100); fire_valid 1-cycle pulse; pot0=0, others {10,20,-20}.
- Word 0x7F7F7F7F, spike src 0 issued 300 times -> all pots saturate at 32767, no wrap. Word 0x80808080 repeated -> floor at -32768.
- tick asserted during ACC -> busy stays high; TICK runs right after ACC; spike_valid held high is not accepted until after fire_valid.
- cfg_we and spike_valid both high in IDLE -> write occurs (mem_we=1), spike_ready=0; spike accepted the next cycle.
- rst_n low in ACC cycle -> all pots 0, fire_vec=0, state IDLE; no fire_valid after release.
